// File: rtl/mac_stats_pkg.sv
// mac_stats_pkg: vector field positions, address map and histogram bin limits for mac_stats_collector.
// The histogram counters exist only when MAC_STATS_SIZE_HIST_EN is defined.
package mac_stats_pkg;
    localparam int RX_GOOD   = 0;
    localparam int RX_BAD    = 1;
    localparam int RX_FCS    = 2;
    localparam int RX_BCAST  = 3;
    localparam int RX_MCAST  = 4;
    localparam int RX_VLAN   = 7;
    localparam int RX_PAUSE  = 8;
    localparam int RX_LEN_LO = 15;
    localparam int RX_LEN_HI = 28;
    localparam int TX_GOOD   = 0;
    localparam int TX_BAD    = 1;
    localparam int TX_BCAST  = 3;
    localparam int TX_MCAST  = 4;
    localparam int TX_LEN_LO = 5;
    localparam int TX_LEN_HI = 18;
    localparam int A_RX_GOOD  = 0;
    localparam int A_RX_BAD   = 1;
    localparam int A_RX_FCS   = 2;
    localparam int A_RX_BCAST = 3;
    localparam int A_RX_MCAST = 4;
    localparam int A_RX_VLAN  = 5;
    localparam int A_RX_PAUSE = 6;
    localparam int A_RX_BYTES = 7;
    localparam int A_TX_GOOD  = 8;
    localparam int A_TX_BAD   = 9;
    localparam int A_TX_BCAST = 10;
    localparam int A_TX_MCAST = 11;
    localparam int A_TX_BYTES = 12;
    localparam int A_OVF      = 13;
    localparam int A_HIST0    = 16;
    localparam int N_BASE     = 13;
    localparam int N_HIST     = 7;
`ifdef MAC_STATS_SIZE_HIST_EN
    localparam int N_CNT = N_BASE + N_HIST;
`else
    localparam int N_CNT = N_BASE;
`endif
    // Upper (inclusive) length of every bin except the last open-ended one.
    localparam int HIST_LIM [N_HIST-1] = '{64, 127, 255, 511, 1023, 1518};

    function automatic int hist_bin(input logic [13:0] len);
        int b = 0;
        for (int k = 0; k < N_HIST - 1; k++)
            if (int'(len) > HIST_LIM[k]) b = k + 1;
        return b;
    endfunction

    // Counter index to read address: base counters map 1:1, histogram bins start at A_HIST0.
    function automatic int cnt_addr(input int i);
        return i < N_BASE ? i : i - N_BASE + A_HIST0;
    endfunction
endpackage

// File: rtl/mac_stats_counter.sv
// mac_stats_counter: CNT_WIDTH accumulator with increment, clear, saturate-or-wrap and sticky overflow.
module mac_stats_counter #(
    parameter int CNT_WIDTH = 48,
    parameter bit SATURATE  = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 inc_i,
    input  logic [CNT_WIDTH-1:0] inc_val_i,
    input  logic                 clear_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 ovf_o
);
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d, base;
    logic [CNT_WIDTH:0]   sum;
    logic                 ovf_q, carry;

    // A clear concurrent with an increment leaves exactly that increment.
    always_comb begin
        base  = clear_i ? '0 : cnt_q;
        sum   = {1'b0, base} + {1'b0, inc_val_i};
        carry = inc_i & sum[CNT_WIDTH];
        cnt_d = !inc_i ? base : (carry && SATURATE) ? '1 : sum[CNT_WIDTH-1:0];
    end

    // Counter and sticky overflow registers.
    always_ff @(posedge clk_i or negedge reset_n_i)
        if (!reset_n_i) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= (ovf_q & ~clear_i) | carry;
        end

    assign cnt_o = cnt_q;
    assign ovf_o = ovf_q;
endmodule

// File: rtl/mac_stats_collector.sv
// mac_stats_collector: 10G MAC rx/tx statistics vector decoder with snapshot/read port and frame pulses.
// Define MAC_STATS_SIZE_HIST_EN to add the rx good-frame length histogram at addresses 16-22.
module mac_stats_collector
    import mac_stats_pkg::*;
#(
    parameter int CNT_WIDTH  = 48,
    parameter bit SATURATE   = 1'b1,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic [29:0]           rx_stats_vector_i,
    input  logic                  rx_stats_valid_i,
    input  logic [25:0]           tx_stats_vector_i,
    input  logic                  tx_stats_valid_i,
    input  logic                  snapshot_i,
    input  logic                  clear_on_snap_i,
    input  logic                  rd_req_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic                  rd_ack_o,
    output logic [63:0]           rd_data_o,
    output logic                  rx_frame_pulse_o,
    output logic                  tx_frame_pulse_o
);
    logic                 rx_v_q, tx_v_q, rx_good, tx_good, clear, unused_bits;
    logic [29:0]          rx_vec_q;
    logic [25:0]          tx_vec_q;
    logic [13:0]          rx_len, tx_len;
    logic [N_CNT-1:0]     inc_en, ovf, ovf_shadow_q;
    logic [CNT_WIDTH-1:0] inc_val [N_CNT];
    logic [CNT_WIDTH-1:0] cnt [N_CNT];
    logic [CNT_WIDTH-1:0] shadow_q [N_CNT];
    logic [63:0]          rd_mux;

    // Stage 1: register the MAC vectors unconditionally; reset discards an in-flight frame.
    always_ff @(posedge clk_i or negedge reset_n_i)
        if (!reset_n_i) begin
            rx_v_q   <= 1'b0;
            tx_v_q   <= 1'b0;
            rx_vec_q <= '0;
            tx_vec_q <= '0;
        end else begin
            rx_v_q   <= rx_stats_valid_i;
            tx_v_q   <= tx_stats_valid_i;
            rx_vec_q <= rx_stats_vector_i;
            tx_vec_q <= tx_stats_vector_i;
        end

    assign rx_frame_pulse_o = rx_v_q;
    assign tx_frame_pulse_o = tx_v_q;
    assign clear            = snapshot_i & clear_on_snap_i;
    assign unused_bits      = ^{rx_vec_q[29], rx_vec_q[14:9], rx_vec_q[6:5], tx_vec_q[25:19], tx_vec_q[2]};

    // Stage 2 decode: one vector may bump several counters; byte counters take good frames only.
    always_comb begin
        rx_len  = rx_vec_q[RX_LEN_HI:RX_LEN_LO];
        tx_len  = tx_vec_q[TX_LEN_HI:TX_LEN_LO];
        rx_good = rx_v_q & rx_vec_q[RX_GOOD];
        tx_good = tx_v_q & tx_vec_q[TX_GOOD];
        inc_en  = '0;
        for (int i = 0; i < N_CNT; i++) inc_val[i] = CNT_WIDTH'(1);
        inc_en[A_RX_GOOD]  = rx_good;
        inc_en[A_RX_BAD]   = rx_v_q & rx_vec_q[RX_BAD];
        inc_en[A_RX_FCS]   = rx_v_q & rx_vec_q[RX_FCS];
        inc_en[A_RX_BCAST] = rx_v_q & rx_vec_q[RX_BCAST];
        inc_en[A_RX_MCAST] = rx_v_q & rx_vec_q[RX_MCAST];
        inc_en[A_RX_VLAN]  = rx_v_q & rx_vec_q[RX_VLAN];
        inc_en[A_RX_PAUSE] = rx_v_q & rx_vec_q[RX_PAUSE];
        inc_en[A_RX_BYTES] = rx_good;
        inc_en[A_TX_GOOD]  = tx_good;
        inc_en[A_TX_BAD]   = tx_v_q & tx_vec_q[TX_BAD];
        inc_en[A_TX_BCAST] = tx_v_q & tx_vec_q[TX_BCAST];
        inc_en[A_TX_MCAST] = tx_v_q & tx_vec_q[TX_MCAST];
        inc_en[A_TX_BYTES] = tx_good;
        inc_val[A_RX_BYTES] = CNT_WIDTH'(rx_len);
        inc_val[A_TX_BYTES] = CNT_WIDTH'(tx_len);
`ifdef MAC_STATS_SIZE_HIST_EN
        for (int k = 0; k < N_HIST; k++) inc_en[N_BASE + k] = rx_good && hist_bin(rx_len) == k;
`endif
    end

    for (genvar g = 0; g < N_CNT; g++) begin : g_cnt
        mac_stats_counter #(.CNT_WIDTH(CNT_WIDTH), .SATURATE(SATURATE)) u_cnt (
            .clk_i     (clk_i),
            .reset_n_i (reset_n_i),
            .inc_i     (inc_en[g]),
            .inc_val_i (inc_val[g]),
            .clear_i   (clear),
            .cnt_o     (cnt[g]),
            .ovf_o     (ovf[g])
        );
    end

    // Shadow bank captures the pre-increment live values and flags on snapshot.
    always_ff @(posedge clk_i or negedge reset_n_i)
        if (!reset_n_i) begin
            shadow_q     <= '{default: '0};
            ovf_shadow_q <= '0;
        end else if (snapshot_i) begin
            shadow_q     <= cnt;
            ovf_shadow_q <= ovf;
        end

    // Read mux over the shadow bank; unmapped addresses read zero.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < N_CNT; i++)
            if (rd_addr_i == ADDR_WIDTH'(cnt_addr(i))) rd_mux = 64'(shadow_q[i]);
        if (rd_addr_i == ADDR_WIDTH'(A_OVF)) rd_mux = 64'(ovf_shadow_q);
    end

    // Registered read response; data holds between reads.
    always_ff @(posedge clk_i or negedge reset_n_i)
        if (!reset_n_i) begin
            rd_ack_o  <= 1'b0;
            rd_data_o <= '0;
        end else begin
            rd_ack_o <= rd_req_i;
            if (rd_req_i) rd_data_o <= rd_mux;
        end
endmodule

// File: tb/tb_mac_stats_collector.sv
// tb_mac_stats_collector: scoreboard bench for mac_stats_collector (saturating and wrapping instances).
module tb_mac_stats_collector;
    localparam logic [29:0] RXG   = 30'h1;
    localparam logic [29:0] RXBAD = 30'h2;
    localparam logic [29:0] RXFCS = 30'h4;
    localparam logic [29:0] RXBC  = 30'h8;
    localparam logic [25:0] TXG   = 26'h1;
    localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF;
`ifdef MAC_STATS_SIZE_HIST_EN
    localparam logic [63:0] H = 64'd1;
`else
    localparam logic [63:0] H = 64'd0;
`endif

    logic        clk = 1'b0, reset_n = 1'b0;
    logic [29:0] rx_vec = '0;
    logic [25:0] tx_vec = '0;
    logic        rx_v = 1'b0, tx_v = 1'b0, snap_r = 1'b0, clr_r = 1'b0, rd_req = 1'b0;
    logic [4:0]  rd_addr = '0;
    logic        rd_ack, rd_ack_w, rx_pulse, rx_pulse_w, tx_pulse, tx_pulse_w;
    logic [63:0] rd_data, rd_data_w;

    typedef struct {
        string       tag;
        logic [63:0] exp;
        logic [63:0] exp_w;
    } rd_t;
    rd_t sb[$];
    rd_t cur;
    int  checks = 0, errors = 0, rx_pulses = 0, tx_pulses = 0;

    always #5 clk = ~clk;

    mac_stats_collector #(.CNT_WIDTH(48), .SATURATE(1'b1), .ADDR_WIDTH(5)) dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .rx_stats_vector_i(rx_vec), .rx_stats_valid_i(rx_v),
        .tx_stats_vector_i(tx_vec), .tx_stats_valid_i(tx_v),
        .snapshot_i(snap_r), .clear_on_snap_i(clr_r),
        .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_ack_o(rd_ack), .rd_data_o(rd_data),
        .rx_frame_pulse_o(rx_pulse), .tx_frame_pulse_o(tx_pulse)
    );

    mac_stats_collector #(.CNT_WIDTH(48), .SATURATE(1'b0), .ADDR_WIDTH(5)) dut_w (
        .clk_i(clk), .reset_n_i(reset_n),
        .rx_stats_vector_i(rx_vec), .rx_stats_valid_i(rx_v),
        .tx_stats_vector_i(tx_vec), .tx_stats_valid_i(tx_v),
        .snapshot_i(snap_r), .clear_on_snap_i(clr_r),
        .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_ack_o(rd_ack_w), .rd_data_o(rd_data_w),
        .rx_frame_pulse_o(rx_pulse_w), .tx_frame_pulse_o(tx_pulse_w)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        rx_v = 1'b0; tx_v = 1'b0; snap_r = 1'b0; clr_r = 1'b0; rd_req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic rx(input logic [13:0] len, input logic [29:0] flags);
        rx_vec = flags; rx_vec[28:15] = len; rx_v = 1'b1;
    endtask

    task automatic tx(input logic [13:0] len, input logic [25:0] flags);
        tx_vec = flags; tx_vec[18:5] = len; tx_v = 1'b1;
    endtask

    task automatic snap(input logic clr);
        snap_r = 1'b1; clr_r = clr;
    endtask

    task automatic rd2(input string tag, input logic [4:0] addr, input logic [63:0] exp, input logic [63:0] exp_w);
        rd_req = 1'b1; rd_addr = addr;
        sb.push_back('{tag, exp, exp_w});
    endtask

    task automatic rd(input string tag, input logic [4:0] addr, input logic [63:0] exp);
        rd2(tag, addr, exp, exp);
    endtask

    // Monitor: count pulses and retire read responses against the scoreboard.
    always @(negedge clk) begin
        if (rx_pulse) rx_pulses++;
        if (tx_pulse) tx_pulses++;
        if (rd_ack !== rd_ack_w) check("ack_w", 64'(rd_ack_w), 64'(rd_ack));
        if (rd_ack) begin
            if (sb.size() == 0) check("spurious_ack", 64'(rd_ack), 64'd0);
            else begin
                cur = sb.pop_front();
                check(cur.tag, rd_data, cur.exp);
                check({cur.tag, "_w"}, rd_data_w, cur.exp_w);
            end
        end
    end

    initial begin
        #1;
        check("rst_rd_data", rd_data, 64'd0);
        check("rst_rd_ack", 64'(rd_ack), 64'd0);
        check("rst_rx_pulse", 64'(rx_pulse), 64'd0);
        check("rst_tx_pulse", 64'(tx_pulse), 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        rd("rst_rx_good", 0, 0); tick();
        rd("rst_rx_bytes", 7, 0); tick();
        rd("rst_ovf", 13, 0); tick();

        // three good rx frames, bcast on the second
        rx(64, RXG); tick();
        rx(100, RXG | RXBC); tick();
        rx(1518, RXG); tick();
        idle(2);
        check("rx_pulses_3", 64'(rx_pulses), 64'd3);
        snap(1'b0); tick();
        rd("t1_rx_good", 0, 3); tick();
        rd("t1_bcast", 3, 1); tick();
        rd("t1_bytes", 7, 1682); tick();
        rd("t1_bad", 1, 0); tick();
        rd("t1_hist_le64", 16, H); tick();
        rd("t1_hist_65", 17, H); tick();
        rd("t1_hist_1024", 21, H); tick();

        // bad+fcs rx frame with a good tx frame in the same cycle
        rx(200, RXBAD | RXFCS); tx(60, TXG); tick();
        idle(2);
        check("rx_pulses_4", 64'(rx_pulses), 64'd4);
        check("tx_pulses_1", 64'(tx_pulses), 64'd1);
        snap(1'b0); tick();
        rd("t2_rx_bad", 1, 1); tick();
        rd("t2_rx_fcs", 2, 1); tick();
        rd("t2_rx_bytes", 7, 1682); tick();
        rd("t2_rx_good", 0, 3); tick();
        rd("t2_tx_good", 8, 1); tick();
        rd("t2_tx_bytes", 12, 60); tick();
        rd("t2_tx_bad", 9, 0); tick();

        // clear-on-snap: tx increment lands in the snap cycle, rx frame valid in the snap cycle
        tx(100, TXG); tick();
        snap(1'b1); rx(64, RXG); tick();
        idle(2);
        rd("t3_rx_good_pre", 0, 3); tick();
        rd("t3_bytes_pre", 7, 1682); tick();
        rd("t3_tx_bytes_pre", 12, 60); tick();
        snap(1'b0); rd("t3_rd_during_snap", 7, 1682); tick();
        rd("t3_bytes_post", 7, 64); tick();
        rd("t3_rx_good_post", 0, 1); tick();
        rd("t3_tx_bytes_post", 12, 100); tick();
        rd("t3_tx_good_post", 8, 1); tick();
        rd("t3_rx_bad_post", 1, 0); tick();
        rd("t3_ovf", 13, 0); tick();

        // saturate vs wrap on rx_good preloaded to 2^48-2
        idle(2);
        force dut.g_cnt[0].u_cnt.cnt_q = 48'hFFFF_FFFF_FFFE;
        force dut_w.g_cnt[0].u_cnt.cnt_q = 48'hFFFF_FFFF_FFFE;
        tick();
        release dut.g_cnt[0].u_cnt.cnt_q;
        release dut_w.g_cnt[0].u_cnt.cnt_q;
        rx(10, RXG); tick();
        rx(10, RXG); tick();
        rx(10, RXG); tick();
        idle(2);
        snap(1'b1); tick();
        rd2("t4_rx_good", 0, ONES, 64'd1); tick();
        rd("t4_ovf", 13, 1); tick();
        rd("t4_bytes", 7, 94); tick();
        idle(2);
        check("t4_rd_hold", rd_data, 64'd94);
        rx(77, RXG); tick();
        idle(2);
        snap(1'b0); tick();
        rd("t4_ovf_cleared", 13, 0); tick();
        rd("t4_bytes_after", 7, 77); tick();
        idle(1);

        // reset between stage 1 and stage 2 of a frame
        rx(64, RXG); tick();
        #1 reset_n = 1'b0;
        @(negedge clk);
        check("t5_rst_rd_data", rd_data, 64'd0);
        reset_n = 1'b1;
        snap(1'b0); tick();
        rd("t5_rx_good_zero", 0, 0); tick();
        rd("t5_bytes_zero", 7, 0); tick();
        rx(64, RXG); tick();
        idle(2);
        snap(1'b0); tick();
        rd("t5_rx_good_once", 0, 1); tick();
        rd("t5_bytes_once", 7, 64); tick();

        // histogram bins and unmapped addresses
        snap(1'b1); tick();
        rx(64, RXG); tick();
        rx(65, RXG); tick();
        rx(1519, RXG); tick();
        idle(2);
        snap(1'b0); tick();
        rd("t6_hist_le64", 16, H); tick();
        rd("t6_hist_65", 17, H); tick();
        rd("t6_hist_gt1518", 22, H); tick();
        rd("t6_hist_1024", 21, 0); tick();
        rd("t6_bytes", 7, 1648); tick();
        rd("t6_ovf", 13, 0); tick();
        rd("t6_addr14", 14, 0); tick();
        rd("t6_addr15", 15, 0); tick();
        rd("t6_addr31", 31, 0); tick();

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        check("sb_drain", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
